// File: rtl/lo_pkg.sv
// Shared types and constants for the LO tuning controller.
// LFSR constants are only used when LO_DITHER_EN is defined.
package lo_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        MUTE   = 3'd2,
        LOAD   = 3'd3,
        SETTLE = 3'd4
    } lo_state_t;

    localparam int unsigned LFSR_W    = 16;
    // Galois right-shift taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    // Per-cycle control from the sequencer to the phase accumulator
    typedef struct packed {
        logic acc_clr;
        logic ftw_wr;
        logic load;
        logic pend_rst;
    } lo_ctrl_t;

    typedef longint unsigned u64_t;

    // Tuning word for output frequency f at sample rate fs
    function automatic u64_t ftw_from_hz(real f, real fs, int unsigned acc_w);
        return u64_t'(f / fs * (2.0 ** acc_w));
    endfunction

endpackage

// File: rtl/lo_phase_acc.sv
// Phase accumulator, FTW register and registered LUT address.
// Optional LFSR dither on the truncated bits when LO_DITHER_EN is defined.
module lo_phase_acc
    import lo_pkg::*;
#(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  lo_ctrl_t          ctrl_i,
    input  logic [ACC_W-1:0]  cfg_ftw_i,
    input  logic [ACC_W-1:0]  pend_ftw_i,
    output logic [ADDR_W-1:0] phase_addr_o
);

    localparam int unsigned TRUNC_W = ACC_W - ADDR_W;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  ftw_q, ftw_d;
    logic [ADDR_W-1:0] phase_addr_q, phase_addr_d;

    // Next accumulator / tuning word
    always_comb begin
        ftw_d = ftw_q;
        acc_d = acc_q + ftw_q;
        if (ctrl_i.load) begin
            ftw_d = pend_ftw_i;
            acc_d = ctrl_i.pend_rst ? '0 : acc_q + pend_ftw_i;
        end else if (ctrl_i.ftw_wr) begin
            ftw_d = cfg_ftw_i;
        end
        if (ctrl_i.acc_clr) begin
            acc_d = '0;
        end
    end

`ifdef LO_DITHER_EN
    localparam int unsigned DITH_W = (TRUNC_W > LFSR_W) ? LFSR_W : TRUNC_W;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_POLY : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Dither sits at the top of the truncated field so its carry reaches the address
    generate
        if (DITH_W > 0) begin : g_dith
            assign phase_addr_d = ADDR_W'((acc_d + (ACC_W'(lfsr_q[DITH_W-1:0]) << (TRUNC_W - DITH_W))) >> TRUNC_W);
        end else begin : g_nodith
            assign phase_addr_d = ADDR_W'(acc_d >> TRUNC_W);
        end
    endgenerate
`else
    assign phase_addr_d = ADDR_W'(acc_d >> TRUNC_W);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            ftw_q        <= '0;
            phase_addr_q <= '0;
        end else begin
            acc_q        <= acc_d;
            ftw_q        <= ftw_d;
            phase_addr_q <= phase_addr_d;
        end
    end

    assign phase_addr_o = phase_addr_q;

endmodule

// File: rtl/lo_tune_ctrl.sv
// LO tuning sequencer: glitch-free FTW swap (mute, load, settle, unmute).
// Build option LO_DITHER_EN enables LFSR dither of the LUT address.
module lo_tune_ctrl
    import lo_pkg::*;
#(
    parameter int unsigned ACC_W         = 32,
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned MUTE_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cfg_valid,
    input  logic [ACC_W-1:0]  cfg_ftw,
    input  logic              cfg_phase_rst,
    output logic              cfg_ready,
    output logic [ADDR_W-1:0] phase_addr,
    output logic              mix_en,
    output logic              busy
);

    localparam int unsigned CNT_MAX = (MUTE_CYCLES > SETTLE_CYCLES) ? MUTE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    lo_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] pend_ftw_q, pend_ftw_d;
    logic             pend_rst_q, pend_rst_d;
    logic             cfg_ready_q, mix_en_q, busy_q;
    logic             hs_c;
    lo_ctrl_t         ctrl_c;

    assign hs_c = cfg_valid && cfg_ready_q;

    // Next state, counters, pending update and accumulator control
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pend_ftw_d      = pend_ftw_q;
        pend_rst_d      = pend_rst_q;
        ctrl_c          = '0;
        ctrl_c.pend_rst = pend_rst_q;

        // In IDLE the tuning word is written directly, even while disabled
        if (state_q == IDLE && hs_c) begin
            ctrl_c.ftw_wr = 1'b1;
        end

        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                end
                RUN: begin
                    if (hs_c) begin
                        pend_ftw_d = cfg_ftw;
                        pend_rst_d = cfg_phase_rst;
                        state_d    = MUTE;
                        cnt_d      = CNT_W'(MUTE_CYCLES - 1);
                    end
                end
                MUTE: begin
                    if (cnt_q == '0) begin
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                LOAD: begin
                    ctrl_c.load = 1'b1;
                    state_d     = SETTLE;
                    cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        ctrl_c.acc_clr = (state_d == IDLE);
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_ftw_q  <= '0;
            pend_rst_q  <= 1'b0;
            cfg_ready_q <= 1'b0;
            mix_en_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_ftw_q  <= pend_ftw_d;
            pend_rst_q  <= pend_rst_d;
            cfg_ready_q <= (state_d == IDLE) || (state_d == RUN);
            mix_en_q    <= (state_d == RUN);
            busy_q      <= (state_d == MUTE) || (state_d == LOAD) || (state_d == SETTLE);
        end
    end

    lo_phase_acc #(
        .ACC_W (ACC_W),
        .ADDR_W(ADDR_W)
    ) u_phase_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl_i      (ctrl_c),
        .cfg_ftw_i   (cfg_ftw),
        .pend_ftw_i  (pend_ftw_q),
        .phase_addr_o(phase_addr)
    );

    assign cfg_ready = cfg_ready_q;
    assign mix_en    = mix_en_q;
    assign busy      = busy_q;

endmodule

// File: doc/lo_tune_ctrl.md
# lo_tune_ctrl

Local-oscillator tuning controller that sequences the receive mixer. It owns the phase accumulator feeding the sin/cos lookup table, which produces the mixer's `sin_in`/`cos_in`. It accepts frequency-tuning-word (FTW) updates over a valid/ready handshake and applies them glitch-free: mute the mixer, swap the FTW, optionally reset phase, wait for LUT settle, unmute. It sits between the host/config path and the LUT+mixer pair.

## Interface
Parameters:
- `ACC_W`, 32, phase accumulator width.
- `ADDR_W`, 10, LUT address width; must be ≤ `ACC_W`.
- `MUTE_CYCLES`, 4, cycles the mixer is muted before an FTW swap; ≥1.
- `SETTLE_CYCLES`, 2, LUT + mixer pipeline depth waited after the swap; ≥1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  run request; low forces IDLE.
- `cfg_valid`  in  1  FTW update request.
- `cfg_ftw`  in  ACC_W  new tuning word, unsigned.
- `cfg_phase_rst`  in  1  sampled with `cfg_valid`; clear the accumulator at swap.
- `cfg_ready`  out  1  update accepted when `cfg_valid && cfg_ready`.
- `phase_addr`  out  ADDR_W  registered LUT address.
- `mix_en`  out  1  mixer output enable; low means the mixer is muted.
- `busy`  out  1  a retune is in progress (MUTE, LOAD or SETTLE).

## Operation
- State machine: IDLE, RUN, MUTE, LOAD, SETTLE.
- **IDLE**
  - Accumulator held at 0; `mix_en`=0; `cfg_ready`=1.
  - A handshake writes `ftw` directly, with no mute.
  - `enable`=1 → SETTLE.
- **RUN**
  - Each cycle: `acc <= acc + ftw`, modulo 2^ACC_W, wrap silent.
  - `mix_en`=1; `cfg_ready`=1.
  - Handshake → latch `pend_ftw` and `pend_rst`, go to MUTE.
- **MUTE**
  - `mix_en`=0; accumulator keeps running on the old FTW.
  - Counter loads `MUTE_CYCLES-1` on entry; at 0 → LOAD.
- **LOAD** (1 cycle)
  - `ftw <= pend_ftw`.
  - `acc <= pend_rst ? 0 : acc + pend_ftw`.
  - → SETTLE.
- **SETTLE**
  - `mix_en`=0; accumulator runs.
  - Counter loads `SETTLE_CYCLES-1` on entry; at 0 → RUN.
- `cfg_ready`=0 in MUTE, LOAD and SETTLE; `busy`=1 in the same states.
- `enable`=0 in any state → IDLE next cycle.
  - `acc` is cleared; pending update discarded; `ftw` retains its last value.
- `phase_addr <= acc_next[ACC_W-1 -: ADDR_W]`, registered every cycle in every state.
- Reset values: state IDLE, `acc`=0, `ftw`=0, `phase_addr`=0, `mix_en`=0, `busy`=0, `cfg_ready`=0.
  - `cfg_ready` rises the first cycle after reset release.
- Reset mid-retune aborts immediately; pending FTW is lost.

## Timing
- Handshake in RUN at cycle T:
  - `mix_en` falls at T+1.
  - LOAD occurs at T+1+MUTE_CYCLES.
  - `mix_en` rises at T+2+MUTE_CYCLES+SETTLE_CYCLES.
  - Default total: 7 cycles muted.
- `phase_addr` reflects the new FTW's increment starting the cycle after LOAD.
- IDLE→RUN after `enable` rises: `mix_en` high after 1+SETTLE_CYCLES cycles.
- `cfg_valid` held while `cfg_ready`=0 is not consumed; the requester must hold it.

## Configuration
- `LO_DITHER_EN` defined:
  - A 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to seed) advances every cycle.
  - Its low `ACC_W-ADDR_W` bits (capped at 16) are added to the truncated bits before `phase_addr` extraction; this spreads truncation spurs.
  - The accumulator itself is not modified.
- `LO_DITHER_EN` undefined: plain truncation; no LFSR logic.

## Structure
- Shared package `lo_pkg`:
  - state enum `lo_state_t` (IDLE, RUN, MUTE, LOAD, SETTLE);
  - LFSR polynomial and seed constants;
  - helper function `ftw_from_hz(f, fs)` for benches.
- One natural sub-module, `lo_phase_acc`: accumulator, FTW register, `phase_addr` register and optional dither.
- The FSM and counters stay in the top.

## Test plan
- Reset, then `enable`=1 with `ftw`=0 → `mix_en`=0 for 3 cycles, then 1; `phase_addr` stays 0.
- ACC_W=32, ADDR_W=10: load `cfg_ftw`=32'h0040_0000 in IDLE, enable → `phase_addr` increments by 1 per cycle and wraps 1023→0.
- In RUN, `cfg_ftw`=32'h0080_0000 with `cfg_phase_rst`=1 → `busy` high for 7 cycles, `cfg_ready` low for those 7 cycles; `phase_addr` restarts from 0 then steps by 2.
- Drop `enable` during MUTE → IDLE next cycle; `mix_en`=0, `acc`=0, old FTW retained, pending FTW discarded.
- Assert `rst_n`=0 asynchronously mid-SETTLE → all outputs at reset values without a clock edge.
- With `LO_DITHER_EN` and `ftw`=32'h0040_0000 → `phase_addr` deviates from the undithered sequence by at most +1.
